hdbn_encoder: RTL

HDBN_ENCODER -- requirements
Module: hdbn_encoder

---
 rtl/hdbn_encoder.sv | 81 ++++++++
 1 files changed

// File: rtl/hdbn_encoder.sv
// HDBn line encoder: AMI with ZRUN-zero substitution (B..V), ZRUN=4 is HDB3.
// Symbols pass through a ZRUN-deep tagged delay line so a zero run can be retagged before it leaves.
module hdbn_encoder #(
  parameter int ZRUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic data,
  input  logic in_valid,
  input  logic mode,
  output logic P,
  output logic N,
  output logic out_valid,
  output logic viol
);

  localparam logic [1:0] T_ZERO = 2'd0;
  localparam logic [1:0] T_MARK = 2'd1;
  localparam logic [1:0] T_B    = 2'd2;
  localparam logic [1:0] T_V    = 2'd3;

  logic [ZRUN-1:0]       vld_pipe, vld_nxt;
  logic [ZRUN-1:0][1:0]  tag_pipe, tag_nxt;
  logic                  parity, parity_nxt;
  logic                  last_pos;
  logic                  leave_vld, pulse, pol, all_zero;
  logic [1:0]            leave_tag;

  always_comb begin
    vld_nxt    = {vld_pipe[ZRUN-2:0], 1'b1};
    tag_nxt    = {tag_pipe[ZRUN-2:0], (data ? T_MARK : T_ZERO)};
    leave_vld  = vld_pipe[ZRUN-1];
    leave_tag  = tag_pipe[ZRUN-1];
    // Parity must include the symbol leaving on this same edge before the B decision.
    parity_nxt = parity;
    if (leave_vld) begin
      case (leave_tag)
        T_MARK, T_B: parity_nxt = ~parity;
        T_V:         parity_nxt = 1'b0;
        default:     parity_nxt = parity;
      endcase
    end
    all_zero = &vld_nxt;
    for (int i = 0; i < ZRUN; i++)
      if (tag_nxt[i] != T_ZERO) all_zero = 1'b0;
    if (mode && all_zero) begin
      tag_nxt[0] = T_V;
      if (!parity_nxt) tag_nxt[ZRUN-1] = T_B;
    end
    pulse = leave_vld && (leave_tag != T_ZERO);
    pol   = (leave_tag == T_V) ? last_pos : ~last_pos;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      parity    <= 1'b0;
      last_pos  <= 1'b0;
      out_valid <= 1'b0;
      P         <= 1'b0;
      N         <= 1'b0;
      viol      <= 1'b0;
    end else if (in_valid) begin
      vld_pipe  <= vld_nxt;
      tag_pipe  <= tag_nxt;
      parity    <= parity_nxt;
      if (pulse) last_pos <= pol;
      out_valid <= leave_vld;
      P         <= pulse && pol;
      N         <= pulse && !pol;
      viol      <= leave_vld && (leave_tag == T_V);
    end else begin
      out_valid <= 1'b0;
      P         <= 1'b0;
      N         <= 1'b0;
      viol      <= 1'b0;
    end
  end

endmodule
